// File: rtl/lcd_spi_pkg.sv
// Shared constants for the LCD SPI receiver: opcodes, decoder states, coordinate width.
// Latency: n/a (definitions only).
// Backpressure: n/a; the receiver never stalls the LCD host.
package lcd_spi_pkg;

  localparam int COORD_W = 12;

  localparam logic [7:0] OP_SLPIN   = 8'h10;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_RASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CASET = 3'd1,
    ST_RASET = 3'd2,
    ST_RAMWR = 3'd3,
    ST_PARAM = 3'd4
  } state_t;

  typedef logic [COORD_W-1:0] coord_t;

  // Saturate a 16-bit window coordinate to the panel limit.
  function automatic coord_t clip_coord(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim[COORD_W-1:0] : v[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/lcd_spi_rx_if.sv
// Decoded output bus of the LCD SPI receiver (commands, parameters, pixels, status).
// Latency: n/a; all members are registered by the driver.
// Backpressure: none; consumers must accept every one-cycle pulse.
// Optional LCD_SPI_RX_RGB888_EN adds the expanded 24-bit pixel.
interface lcd_spi_rx_if;
  import lcd_spi_pkg::*;

  logic         cmd_valid;
  logic [7:0]   cmd_byte;
  logic         par_valid;
  logic [7:0]   par_byte;
  logic         pix_valid;
  logic [15:0]  pix_data;
  coord_t       pix_x;
  coord_t       pix_y;
  logic         sleep_out;
  logic         disp_on;
  logic         frame_err;
`ifdef LCD_SPI_RX_RGB888_EN
  logic [23:0]  pix_rgb888;
`endif

  modport master (
    output cmd_valid, cmd_byte, par_valid, par_byte, pix_valid, pix_data,
           pix_x, pix_y, sleep_out, disp_on, frame_err
`ifdef LCD_SPI_RX_RGB888_EN
    , output pix_rgb888
`endif
  );

  modport slave (
    input cmd_valid, cmd_byte, par_valid, par_byte, pix_valid, pix_data,
          pix_x, pix_y, sleep_out, disp_on, frame_err
`ifdef LCD_SPI_RX_RGB888_EN
    , input pix_rgb888
`endif
  );

endinterface

// File: rtl/lcd_spi_shift.sv
// Synchronizes the LCD pins, detects lcd_clk rising edges and deserializes bytes MSB first.
// Latency: SYNC_STAGES clk from pin to edge detect; byte_valid is combinational on the 8th edge.
// Backpressure: none; a partial byte at lcd_cs rise is dropped and flagged on frame_err.
module lcd_spi_shift #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       lcd_clk,
  input  logic       lcd_cs,
  input  logic       lcd_rs,
  input  logic       lcd_data,
  input  logic       lcd_rstn,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       rs,
  output logic       frame_err,
  output logic       soft_rst
);

  // Pin order {rstn, data, rs, cs, clk}; chip select idles deasserted.
  localparam logic [4:0] PIN_IDLE = 5'b00010;

  logic [4:0] sync_q [SYNC_STAGES];
  logic       sclk, scs, srs, sdata, srstn;
  logic       clk_prev, cs_prev;
  logic [2:0] bit_cnt;
  logic [6:0] shift_q;
  logic       rs_q;
  logic       rise, cs_rise, bit_en;

  assign {srstn, sdata, srs, scs, sclk} = sync_q[SYNC_STAGES-1];
  assign soft_rst   = ~srstn;
  assign rise       = sclk & ~clk_prev;
  assign cs_rise    = scs & ~cs_prev;
  assign bit_en     = rise & ~scs & ~soft_rst;
  assign byte_valid = bit_en & (bit_cnt == 3'd7);
  assign data_byte  = {shift_q, sdata};
  assign rs         = rs_q;
  assign frame_err  = cs_rise & (bit_cnt != 3'd0) & ~soft_rst;

  // Synchronizer chain and edge history; only the hard reset stops them.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= PIN_IDLE;
      clk_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      sync_q[0] <= {lcd_rstn, lcd_data, lcd_rs, lcd_cs, lcd_clk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      clk_prev <= sclk;
      cs_prev  <= scs;
    end
  end

  // Bit counter and shift register; rs is captured with the first bit of each byte.
  always_ff @(posedge clk) begin
    if (!rstn || soft_rst) begin
      bit_cnt <= 3'd0;
      shift_q <= 7'd0;
      rs_q    <= 1'b0;
    end else if (cs_rise) begin
      bit_cnt <= 3'd0;
    end else if (bit_en) begin
      bit_cnt <= bit_cnt + 3'd1;
      shift_q <= {shift_q[5:0], sdata};
      if (bit_cnt == 3'd0) rs_q <= srs;
    end
  end

endmodule

// File: rtl/lcd_spi_rx.sv
// LCD SPI command receiver: decodes opcodes, window setup and RAMWR pixel stream with cursor.
// Latency: outputs pulse 1 clk after the 8th lcd_clk edge is detected.
// Backpressure: none; pulses are single-cycle. Macro LCD_SPI_RX_RGB888_EN adds pix_rgb888.
module lcd_spi_rx
  import lcd_spi_pkg::*;
#(
  parameter int H_RES       = 240,
  parameter int V_RES       = 320,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          lcd_clk,
  input  logic          lcd_cs,
  input  logic          lcd_rs,
  input  logic          lcd_data,
  input  logic          lcd_rstn,
  lcd_spi_rx_if.master  rx
);

  localparam logic [15:0] X_MAX = 16'(H_RES - 1);
  localparam logic [15:0] Y_MAX = 16'(V_RES - 1);

  logic        byte_valid, byte_rs, shift_ferr, soft_rst, rst_all;
  logic [7:0]  rx_byte;
  state_t      state_q, state_d;
  coord_t      xs, xe, ys, ye, cur_x, cur_y;
  logic [15:0] start_q;
  logic [7:0]  end_hi_q, hi_q;
  logic [1:0]  par_cnt;
  logic        hi_have;

  logic        is_cmd, is_data, collect, commit_x, commit_y, do_par, do_pix, idle_err;
  logic [15:0] lim;
  coord_t      lo_c, hi_c, win_lo, win_hi;

  lcd_spi_shift #(.SYNC_STAGES(SYNC_STAGES)) u_shift (
    .clk        (clk),
    .rstn       (rstn),
    .lcd_clk    (lcd_clk),
    .lcd_cs     (lcd_cs),
    .lcd_rs     (lcd_rs),
    .lcd_data   (lcd_data),
    .lcd_rstn   (lcd_rstn),
    .byte_valid (byte_valid),
    .data_byte  (rx_byte),
    .rs         (byte_rs),
    .frame_err  (shift_ferr),
    .soft_rst   (soft_rst)
  );

  assign rst_all = !rstn || soft_rst;

  // Decoder state register.
  always_ff @(posedge clk) begin
    if (rst_all) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next state: commands always win; a window state ends on its 4th data byte.
  always_comb begin
    state_d = state_q;
    if (is_cmd) begin
      case (rx_byte)
        OP_CASET: state_d = ST_CASET;
        OP_RASET: state_d = ST_RASET;
        OP_RAMWR: state_d = ST_RAMWR;
        OP_SLPIN, OP_SLPOUT, OP_DISPOFF, OP_DISPON: state_d = ST_IDLE;
        default:  state_d = ST_PARAM;
      endcase
    end else if (commit_x || commit_y) begin
      state_d = ST_IDLE;
    end
  end

  // Output decode: classify the incoming byte and prepare the clipped, ordered window.
  always_comb begin
    is_cmd   = byte_valid & ~byte_rs;
    is_data  = byte_valid & byte_rs;
    collect  = is_data & ((state_q == ST_CASET) || (state_q == ST_RASET)) & (par_cnt != 2'd3);
    commit_x = is_data & (state_q == ST_CASET) & (par_cnt == 2'd3);
    commit_y = is_data & (state_q == ST_RASET) & (par_cnt == 2'd3);
    do_par   = is_data & ((state_q == ST_PARAM) || (state_q == ST_IDLE));
    idle_err = is_data & (state_q == ST_IDLE);
    do_pix   = is_data & (state_q == ST_RAMWR) & hi_have;
    lim      = (state_q == ST_RASET) ? Y_MAX : X_MAX;
    lo_c     = clip_coord(start_q, lim);
    hi_c     = clip_coord({end_hi_q, rx_byte}, lim);
    win_lo   = (lo_c > hi_c) ? hi_c : lo_c;
    win_hi   = (lo_c > hi_c) ? lo_c : hi_c;
  end

`ifdef LCD_SPI_RX_RGB888_EN
  logic [4:0] r5, b5;
  logic [5:0] g6;
  assign r5 = hi_q[7:3];
  assign g6 = {hi_q[2:0], rx_byte[7:5]};
  assign b5 = rx_byte[4:0];
`endif

  // Output registers, window registers and the RAMWR pixel cursor.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      rx.cmd_valid <= 1'b0;
      rx.cmd_byte  <= 8'd0;
      rx.par_valid <= 1'b0;
      rx.par_byte  <= 8'd0;
      rx.pix_valid <= 1'b0;
      rx.pix_data  <= 16'd0;
      rx.pix_x     <= '0;
      rx.pix_y     <= '0;
      rx.sleep_out <= 1'b0;
      rx.disp_on   <= 1'b0;
      rx.frame_err <= 1'b0;
`ifdef LCD_SPI_RX_RGB888_EN
      rx.pix_rgb888 <= 24'd0;
`endif
      xs       <= '0;
      xe       <= X_MAX[COORD_W-1:0];
      ys       <= '0;
      ye       <= Y_MAX[COORD_W-1:0];
      cur_x    <= '0;
      cur_y    <= '0;
      start_q  <= 16'd0;
      end_hi_q <= 8'd0;
      par_cnt  <= 2'd0;
      hi_q     <= 8'd0;
      hi_have  <= 1'b0;
    end else begin
      rx.cmd_valid <= is_cmd;
      rx.par_valid <= do_par;
      rx.pix_valid <= do_pix;
      rx.frame_err <= shift_ferr | idle_err;
      if (is_cmd) begin
        rx.cmd_byte <= rx_byte;
        par_cnt     <= 2'd0;
        hi_have     <= 1'b0;
        case (rx_byte)
          OP_SLPOUT:  rx.sleep_out <= 1'b1;
          OP_SLPIN:   rx.sleep_out <= 1'b0;
          OP_DISPON:  rx.disp_on   <= 1'b1;
          OP_DISPOFF: rx.disp_on   <= 1'b0;
          OP_RAMWR: begin
            cur_x <= xs;
            cur_y <= ys;
          end
          default: ;
        endcase
      end
      if (do_par) rx.par_byte <= rx_byte;
      if (collect) begin
        par_cnt <= par_cnt + 2'd1;
        case (par_cnt)
          2'd0:    start_q[15:8] <= rx_byte;
          2'd1:    start_q[7:0]  <= rx_byte;
          default: end_hi_q      <= rx_byte;
        endcase
      end
      if (commit_x) begin
        xs      <= win_lo;
        xe      <= win_hi;
        par_cnt <= 2'd0;
      end
      if (commit_y) begin
        ys      <= win_lo;
        ye      <= win_hi;
        par_cnt <= 2'd0;
      end
      if (is_data && state_q == ST_RAMWR) begin
        if (!hi_have) begin
          hi_q    <= rx_byte;
          hi_have <= 1'b1;
        end else begin
          hi_have     <= 1'b0;
          rx.pix_data <= {hi_q, rx_byte};
          rx.pix_x    <= cur_x;
          rx.pix_y    <= cur_y;
`ifdef LCD_SPI_RX_RGB888_EN
          rx.pix_rgb888 <= {r5, r5[4:2], g6, g6[5:4], b5, b5[4:2]};
`endif
          if (cur_x == xe) begin
            cur_x <= xs;
            cur_y <= (cur_y == ye) ? ys : cur_y + 1'b1;
          end else begin
            cur_x <= cur_x + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/lcd_spi_rx.md
LCD_SPI_RX -- requirements
Module: lcd_spi_rx

Interface
REQ-001 SHALL have parameter H_RES, default 240: maximum column count; CASET values are clipped to H_RES-1.
REQ-002 SHALL have parameter V_RES, default 320: maximum row count; RASET values are clipped to V_RES-1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on all LCD input pins.
REQ-004 SHALL have port clk, input, 1: single system clock; all logic is clocked on posedge clk.
REQ-005 SHALL have port rstn, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have inputs lcd_clk, lcd_cs, lcd_rs, lcd_data, lcd_rstn, each 1 bit: SPI serial clock, active-low chip select, 0=command/1=data select, MOSI data (MSB first), and active-low panel reset.
REQ-007 SHALL have outputs cmd_valid (1) and cmd_byte (8): one-cycle pulse with the received command opcode.
REQ-008 SHALL have outputs par_valid (1) and par_byte (8): one-cycle pulse with a parameter byte of any command other than RAMWR.
REQ-009 SHALL have outputs pix_valid (1), pix_data (16, RGB565), pix_x (12) and pix_y (12): one-cycle pixel-write pulse with the pixel's address.
REQ-010 SHALL have outputs sleep_out (1), disp_on (1) and frame_err (1): status levels plus a one-cycle error pulse.

Function
REQ-011 SHALL pass every LCD input through SYNC_STAGES flops, then detect lcd_clk rising edges on the synchronized signal; clk SHALL be at least 4x the lcd_clk frequency.
REQ-012 SHALL, on each detected rising edge while synchronized lcd_cs is 0, shift the synchronized lcd_data into an 8-bit register MSB first and latch lcd_rs on the first bit.
REQ-013 SHALL complete a byte on the 8th bit; the corresponding output pulse SHALL appear exactly 1 clk after the cycle in which the 8th edge is detected.
REQ-014 SHALL, when lcd_cs rises with 1..7 bits captured, discard the partial byte, pulse frame_err for 1 cycle and leave decoder state unchanged.
REQ-015 SHALL NOT reset decoder state on lcd_cs deassertion between bytes; a transaction may span any number of CS frames.
REQ-016 SHALL implement a decoder FSM with states IDLE, CASET, RASET, RAMWR and PARAM.
REQ-017 SHALL treat any command byte (rs=0) as valid in every state: pulse cmd_valid, abort the current state, and select the next state (0x2A to CASET, 0x2B to RASET, 0x2C to RAMWR, 0x11/0x10/0x29/0x28 to IDLE, all others to PARAM).
REQ-018 SHALL set sleep_out=1 on 0x11, sleep_out=0 on 0x10, disp_on=1 on 0x29 and disp_on=0 on 0x28.
REQ-019 SHALL, in CASET, collect 4 data bytes as XS[15:8], XS[7:0], XE[15:8], XE[7:0]; on the 4th byte it SHALL commit xs/xe clipped to H_RES-1, swap them if XS>XE, and return to IDLE; extra bytes SHALL go to par_valid.
REQ-020 SHALL handle RASET identically to CASET, using ys/ye clipped to V_RES-1.
REQ-021 SHALL, on entering RAMWR, set the cursor to (xs, ys); each data-byte pair (high byte first) SHALL produce one pix_valid carrying that cursor.
REQ-022 SHALL then advance the cursor x+1; at x=xe it SHALL wrap x to xs with y+1; at (xe, ye) it SHALL wrap to (xs, ys).
REQ-023 SHALL discard a dangling high byte in RAMWR when a new command arrives, with no pix_valid.
REQ-024 SHALL forward every data byte in PARAM on par_valid; a data byte received in IDLE SHALL pulse par_valid and frame_err.
REQ-025 SHALL assert at most one of cmd_valid, par_valid or pix_valid in any cycle.

Reset
REQ-026 SHALL, with rstn=0 at posedge clk, set every pulse output, pix_data, pix_x, pix_y, cmd_byte and par_byte to 0, sleep_out to 0 and disp_on to 0; xs=ys=0, xe=H_RES-1, ye=V_RES-1; FSM to IDLE; bit counter to 0.
REQ-027 SHALL treat synchronized lcd_rstn=0 as a soft reset with the same effect as rstn, except the synchronizers keep running.
REQ-028 SHALL abort any frame in progress when either reset is asserted, with no frame_err.

Configuration
REQ-029 SHALL support macro LCD_SPI_RX_RGB888_EN: when defined, an output pix_rgb888 (24) SHALL be added, registered with pix_valid, holding {R5,R5[4:2]}, {G6,G6[5:4]}, {B5,B5[4:2]}; when undefined, the port and its logic SHALL be absent and all other behaviour unchanged.

Structure
REQ-030 SHALL take from shared package lcd_spi_pkg the opcode constants (SLPIN 0x10, SLPOUT 0x11, DISPOFF 0x28, DISPON 0x29, CASET 0x2A, RASET 0x2B, RAMWR 0x2C), the FSM state encoding, and the 12-bit coordinate width.
REQ-031 SHALL place the synchronizers, edge detection and byte deserializer in sub-module lcd_spi_shift, which outputs byte_valid, byte, rs and frame_err.

Verification
REQ-032 SHALL verify command 0x11 -> cmd_valid with cmd_byte=0x11, sleep_out=1, and a pulse exactly 1 clk after the 8th edge detect.
REQ-033 SHALL verify CASET 00 02 00 04, RASET 00 01 00 02, RAMWR, then 6 pixels F800 -> pix (2,1),(3,1),(4,1),(2,2),(3,2),(4,2) with data 16'hF800.
REQ-034 SHALL verify a 7th pixel after REQ-033 -> wrap to (2,1).
REQ-035 SHALL verify lcd_cs raised after 5 bits -> frame_err pulse and no byte output; the next full byte decodes correctly.
REQ-036 SHALL verify CASET 01 00 00 05 (XS=256) with H_RES=240 -> xs/xe swapped to 5/239.
REQ-037 SHALL verify lcd_rstn low mid-RAMWR -> FSM IDLE, window defaults restored, sleep_out=0, no pix_valid.
